// File: rtl/pc_unit.sv
// Program counter unit: BOOT/RUN/HALTED sequencing with trap, redirect,
// halt/resume and stall handling.
module pc_unit #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          INCR         = 4,
  parameter int          ALIGN_BITS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             trap,
  input  logic             halt,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] epc,
  output logic             trap_taken,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] RST_PC     = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] TRAP_PC    = WIDTH'(TRAP_VECTOR);
  localparam logic [WIDTH-1:0] STEP       = WIDTH'(INCR);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  // Misaligned vectors would fetch from an illegal address forever, so refuse to build.
  if ((RST_PC & ALIGN_MASK) != '0) begin : g_bad_reset_vector
    $error("pc_unit: RESET_VECTOR is not aligned to ALIGN_BITS");
  end
  if ((TRAP_PC & ALIGN_MASK) != '0) begin : g_bad_trap_vector
    $error("pc_unit: TRAP_VECTOR is not aligned to ALIGN_BITS");
  end

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             trap_taken_q, trap_taken_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] pc_plus;
  logic             target_misaligned;

  assign pc_plus           = pc_q + STEP;
  assign target_misaligned = |(redirect_target & ALIGN_MASK);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epc_d        = epc_q;
    trap_taken_d = 1'b0;
    misalign_d   = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (trap) begin
          pc_d         = TRAP_PC;
          epc_d        = pc_q;
          trap_taken_d = 1'b1;
        end else if (redirect && target_misaligned) begin
          pc_d         = TRAP_PC;
          epc_d        = redirect_target;
          trap_taken_d = 1'b1;
          misalign_d   = 1'b1;
        end else if (redirect) begin
          pc_d = redirect_target;
        end else if (halt) begin
          state_d = HALTED;
        end else if (!stall) begin
          pc_d = pc_plus;
        end
      end
      HALTED: begin
        if (trap) begin
          pc_d         = TRAP_PC;
          epc_d        = pc_q;
          trap_taken_d = 1'b1;
          state_d      = RUN;
        end else if (resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
        pc_d    = RST_PC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RST_PC;
      epc_q        <= '0;
      trap_taken_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      trap_taken_q <= trap_taken_d;
      misalign_q   <= misalign_d;
    end
  end

  assign pc          = pc_q;
  assign pc_next_seq = pc_plus;
  assign fetch_valid = (state_q == RUN) && !stall && !rst;
  assign epc         = epc_q;
  assign trap_taken  = trap_taken_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, randomized run
// against a behavioural model, and an 8-bit instance for PC wrap-around.
module tb_pc_unit;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic        trap;
    logic        halt;
    logic        resume;
    logic        exp_fv;
    logic [31:0] exp_pc;
    logic [31:0] exp_epc;
    logic        exp_tt;
    logic        exp_mis;
  } vec_t;

  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  typedef struct {
    int          mode;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        tt;
    logic        mis;
  } mstate_t;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, trap, halt, resume;
  logic [31:0] redirect_target;
  logic [31:0] pc, pc_next_seq, epc;
  logic        fetch_valid, trap_taken, misalign;

  logic       rst8;
  logic       zero1 = 1'b0;
  logic [7:0] zero8 = 8'h00;
  logic [7:0] pc8, pc_next_seq8, epc8;
  logic       fetch_valid8, trap_taken8, misalign8;

  int      n_vectors     = 0;
  int      n_miscompares = 0;
  int      cur_idx       = 0;
  mstate_t m;
  vec_t    vecs[$];

  always #5 clk = ~clk;

  pc_unit u_dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .trap           (trap),
    .halt           (halt),
    .resume         (resume),
    .pc             (pc),
    .pc_next_seq    (pc_next_seq),
    .fetch_valid    (fetch_valid),
    .epc            (epc),
    .trap_taken     (trap_taken),
    .misalign       (misalign)
  );

  pc_unit #(
    .WIDTH       (8),
    .RESET_VECTOR(32'h0000_00F4),
    .TRAP_VECTOR (32'h0000_0080)
  ) u_dut8 (
    .clk            (clk),
    .rst            (rst8),
    .stall          (zero1),
    .redirect       (zero1),
    .redirect_target(zero8),
    .trap           (zero1),
    .halt           (zero1),
    .resume         (zero1),
    .pc             (pc8),
    .pc_next_seq    (pc_next_seq8),
    .fetch_valid    (fetch_valid8),
    .epc            (epc8),
    .trap_taken     (trap_taken8),
    .misalign       (misalign8)
  );

  // Behavioural model: decide which event wins, then apply its effect.
  function automatic mstate_t model_next(mstate_t s, vec_t v);
    mstate_t n = s;
    bit      bad_jump;
    n.tt  = 1'b0;
    n.mis = 1'b0;
    if (v.rst) begin
      n.mode = M_BOOT;
      n.pc   = 32'h0;
      n.epc  = 32'h0;
      return n;
    end
    if (s.mode == M_BOOT) begin
      n.mode = M_RUN;
      return n;
    end
    bad_jump = (s.mode == M_RUN) && v.redirect && (v.target % 4 != 0);
    if (v.trap) begin
      n.epc  = s.pc;
      n.pc   = 32'h100;
      n.tt   = 1'b1;
      n.mode = M_RUN;
    end else if (bad_jump) begin
      n.epc = v.target;
      n.pc  = 32'h100;
      n.tt  = 1'b1;
      n.mis = 1'b1;
    end else if (s.mode == M_HALT) begin
      if (v.resume) n.mode = M_RUN;
    end else if (v.redirect) begin
      n.pc = v.target;
    end else if (v.halt) begin
      n.mode = M_HALT;
    end else if (!v.stall) begin
      n.pc = s.pc + 32'd4;
    end
    return n;
  endfunction

  function automatic vec_t mk(logic r, logic s, logic rd, logic [31:0] t, logic tr,
                              logic h, logic rs, logic fv, logic [31:0] epc_pc,
                              logic [31:0] e, logic tt, logic mi);
    vec_t v;
    v.rst = r; v.stall = s; v.redirect = rd; v.target = t; v.trap = tr;
    v.halt = h; v.resume = rs; v.exp_fv = fv; v.exp_pc = epc_pc;
    v.exp_epc = e; v.exp_tt = tt; v.exp_mis = mi;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s (vector %0d): got %h, expected %h", name, cur_idx, act, exp);
    end
  endtask

  // Drive inputs after the falling edge, check combinational outputs, then registered ones.
  task automatic apply_stimulus(input vec_t v);
    rst             = v.rst;
    stall           = v.stall;
    redirect        = v.redirect;
    redirect_target = v.target;
    trap            = v.trap;
    halt            = v.halt;
    resume          = v.resume;
    #1;
    check_output("fetch_valid", {31'b0, fetch_valid}, {31'b0, v.exp_fv});
    m = model_next(m, v);
    @(posedge clk);
    #1;
    check_output("pc", pc, v.exp_pc);
    check_output("pc_next_seq", pc_next_seq, v.exp_pc + 32'd4);
    check_output("epc", epc, v.exp_epc);
    check_output("trap_taken", {31'b0, trap_taken}, {31'b0, v.exp_tt});
    check_output("misalign", {31'b0, misalign}, {31'b0, v.exp_mis});
    @(negedge clk);
  endtask

  initial begin
    vec_t        v;
    mstate_t     n;
    logic [7:0]  exp8[5];
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    trap = 1'b0; halt = 1'b0; resume = 1'b0; rst8 = 1'b1;
    m = '{mode: M_BOOT, pc: 32'h0, epc: 32'h0, tt: 1'b0, mis: 1'b0};

    //            rst stl rd  target         trp hlt res fv  pc             epc            tt  mis
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h4,         32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h8,         32'h0,         0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 0, 0, 32'h8,         32'h0,         0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 0, 0, 32'h8,         32'h0,         0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h40,        0, 0, 0, 0, 32'h40,        32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h80,        1, 0, 0, 1, 32'h100,       32'h40,        1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h104,       32'h40,        0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h42,        0, 0, 0, 1, 32'h100,       32'h42,        1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h104,       32'h42,        0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h10,        0, 0, 0, 1, 32'h10,        32'h42,        0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 0, 1, 32'h10,        32'h42,        0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h80,        0, 0, 0, 0, 32'h10,        32'h42,        0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 0, 0, 32'h10,        32'h42,        0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h10,        32'h42,        0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h14,        32'h42,        0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 0, 1, 32'h14,        32'h42,        0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 1, 0, 32'h100,       32'h14,        1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 0, 1, 32'h100,       32'h14,        0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 0, 0, 32'h0,         32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h80,        1, 0, 0, 0, 32'h0,         32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h4,         32'h0,         0, 0));
    vecs.push_back(mk(1, 0, 1, 32'h80,        0, 0, 0, 0, 32'h0,         32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h4,         32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h0,         32'h0,         0, 0));

    @(negedge clk);
    foreach (vecs[i]) begin
      cur_idx = i;
      apply_stimulus(vecs[i]);
    end

    for (int i = 0; i < 400; i++) begin
      cur_idx         = 1000 + i;
      v.rst           = ($urandom_range(0, 39) == 0);
      v.stall         = ($urandom_range(0, 3) == 0);
      v.redirect      = ($urandom_range(0, 4) == 0);
      v.target        = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) v.target = v.target | 32'($urandom_range(1, 3));
      v.trap          = ($urandom_range(0, 9) == 0);
      v.halt          = ($urandom_range(0, 9) == 0);
      v.resume        = ($urandom_range(0, 2) == 0);
      v.exp_fv        = (m.mode == M_RUN) && !v.stall && !v.rst;
      n               = model_next(m, v);
      v.exp_pc        = n.pc;
      v.exp_epc       = n.epc;
      v.exp_tt        = n.tt;
      v.exp_mis       = n.mis;
      apply_stimulus(v);
    end

    exp8[0] = 8'hF4; exp8[1] = 8'hF8; exp8[2] = 8'hFC; exp8[3] = 8'h00; exp8[4] = 8'h04;
    rst8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cur_idx = 2000 + i;
      @(posedge clk);
      #1;
      check_output("pc8", {24'b0, pc8}, {24'b0, exp8[i]});
      check_output("pc_next_seq8", {24'b0, pc_next_seq8}, {24'b0, exp8[i] + 8'd4});
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
